// File: rtl/ring_phase_decoder.sv
// One-hot ring phase decoder with rotation-sequence lock monitor.
// Define RING_DEC_ERR_CNT_EN to build the saturating err_count / clr_err logic.
module ring_phase_decoder #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     index_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   good_cnt_reg, good_cnt_next;
  logic [WIDTH-1:0]   last_reg, last_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic               index_valid_reg, index_valid_next;
  logic               err_pulse_reg, err_pulse_next;
  logic               err_inc;

  logic               onehot;
  logic               match;
  logic [WIDTH-1:0]   expected;
  logic [IDX_W-1:0]   dec_idx;
  logic [IDX_W-1:0]   idx_term [WIDTH];

  assign onehot   = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign expected = {last_reg[WIDTH-2:0], last_reg[WIDTH-1]};
  assign match    = (ring_in == expected);

  // Each bit contributes its own position; OR-ing is a valid encode only when one-hot.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_enc
      assign idx_term[gi] = ring_in[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    dec_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_idx = dec_idx | idx_term[i];
    end
  end

  always_comb begin
    state_next       = state_reg;
    good_cnt_next    = good_cnt_reg;
    last_next        = last_reg;
    index_next       = index_reg;
    index_valid_next = index_valid_reg;
    err_pulse_next   = 1'b0;
    err_inc          = 1'b0;
    if (en) begin
      index_valid_next = onehot;
      index_next       = onehot ? dec_idx : '0;
      case (state_reg)
        HUNT: begin
          if (onehot) begin
            last_next     = ring_in;
            good_cnt_next = CNT_W'(1);
            state_next    = (LOCK_CNT == 1) ? LOCKED : ACQ;
          end
        end
        ACQ: begin
          if (match) begin
            last_next = ring_in;
            if (int'(good_cnt_reg) + 1 >= LOCK_CNT) begin
              good_cnt_next = CNT_W'(LOCK_CNT);
              state_next    = LOCKED;
            end else begin
              good_cnt_next = good_cnt_reg + CNT_W'(1);
            end
          end else if (onehot) begin
            last_next     = ring_in;
            good_cnt_next = CNT_W'(1);
          end else begin
            state_next = HUNT;
          end
        end
        LOCKED: begin
          if (match) begin
            last_next = ring_in;
          end else begin
            err_pulse_next = 1'b1;
            err_inc        = 1'b1;
            if (onehot) begin
              last_next     = ring_in;
              good_cnt_next = CNT_W'(1);
              state_next    = ACQ;
            end else begin
              state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      good_cnt_reg    <= '0;
      last_reg        <= '0;
      index_reg       <= '0;
      index_valid_reg <= 1'b0;
      err_pulse_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      good_cnt_reg    <= good_cnt_next;
      last_reg        <= last_next;
      index_reg       <= index_next;
      index_valid_reg <= index_valid_next;
      err_pulse_reg   <= err_pulse_next;
    end
  end

`ifdef RING_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_reg;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (clr_err) begin
      err_count_reg <= '0;
    end else if (err_inc && !(&err_count_reg)) begin
      err_count_reg <= err_count_reg + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_count_reg;
`else
  logic unused_err_in;
  assign unused_err_in = clr_err ^ err_inc;
  assign err_count     = '0;
`endif

  assign index       = index_reg;
  assign index_valid = index_valid_reg;
  assign locked      = (state_reg == LOCKED);
  assign err_pulse   = err_pulse_reg;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed bench for ring_phase_decoder (WIDTH=4, LOCK_CNT=2, ERR_CNT_W=2).
module tb_ring_phase_decoder;

`ifdef RING_DEC_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] ring_in = 4'b0000;
  logic       clr_err = 1'b0;
  logic [1:0] index;
  logic       index_valid;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_count;

  int errors = 0;
  int checks = 0;

  ring_phase_decoder #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .ring_in(ring_in),
    .clr_err(clr_err),
    .index(index),
    .index_valid(index_valid),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ec(input int n);
    return CNT_ON ? 2'(n) : 2'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [3:0] ring, input logic c);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    ring_in = ring;
    clr_err = c;
    @(posedge clk);
    #1;
    $display("step rst_n=%b en=%b ring=%b clr=%b -> index=%0d valid=%b locked=%b pulse=%b count=%0d",
             r, e, ring, c, index, index_valid, locked, err_pulse, err_count);
  endtask

  task automatic outs(input string tag, input logic [1:0] idx, input logic vld,
                      input logic lck, input logic pls, input logic [1:0] cnt);
    check({tag, ".index"}, 32'(index), 32'(idx));
    check({tag, ".valid"}, 32'(index_valid), 32'(vld));
    check({tag, ".locked"}, 32'(locked), 32'(lck));
    check({tag, ".pulse"}, 32'(err_pulse), 32'(pls));
    check({tag, ".count"}, 32'(err_count), 32'(cnt));
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b1, 4'b0001, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Lock and wrap
    step(1'b1, 1'b1, 4'b0001, 1'b0); outs("seed", 2'd0, 1'b1, 1'b0, 1'b0, ec(0));
    step(1'b1, 1'b1, 4'b0010, 1'b0); outs("lock", 2'd1, 1'b1, 1'b1, 1'b0, ec(0));
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("run2", 2'd2, 1'b1, 1'b1, 1'b0, ec(0));
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("run3", 2'd3, 1'b1, 1'b1, 1'b0, ec(0));
    step(1'b1, 1'b1, 4'b0001, 1'b0); outs("wrap", 2'd0, 1'b1, 1'b1, 1'b0, ec(0));

    // Skip violation, en=0 clears the pulse, then relock
    step(1'b1, 1'b1, 4'b0010, 1'b0); outs("pre_skip", 2'd1, 1'b1, 1'b1, 1'b0, ec(0));
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("skip", 2'd3, 1'b1, 1'b0, 1'b1, ec(1));
    step(1'b1, 1'b0, 4'b0100, 1'b0); outs("skip_idle", 2'd3, 1'b1, 1'b0, 1'b0, ec(1));
    step(1'b1, 1'b1, 4'b0001, 1'b0); outs("relock", 2'd0, 1'b1, 1'b1, 1'b0, ec(1));

    // Illegal sample while locked, then illegal in HUNT is not counted
    step(1'b1, 1'b1, 4'b0011, 1'b0); outs("illegal", 2'd0, 1'b0, 1'b0, 1'b1, ec(2));
    step(1'b1, 1'b1, 4'b0000, 1'b0); outs("hunt_zero", 2'd0, 1'b0, 1'b0, 1'b0, ec(2));
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("hunt_seed", 2'd2, 1'b1, 1'b0, 1'b0, ec(2));
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("hunt_lock", 2'd3, 1'b1, 1'b1, 1'b0, ec(2));

    // Hold with en=0 while ring_in toggles garbage
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
      outs($sformatf("hold%0d", i), 2'd3, 1'b1, 1'b1, 1'b0, ec(2));
    end

    // Saturation of the 2-bit counter
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("sat_v1", 2'd2, 1'b1, 1'b0, 1'b1, ec(3));
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("sat_l1", 2'd3, 1'b1, 1'b1, 1'b0, ec(3));
    step(1'b1, 1'b1, 4'b0010, 1'b0); outs("sat_v2", 2'd1, 1'b1, 1'b0, 1'b1, ec(3));
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("sat_l2", 2'd2, 1'b1, 1'b1, 1'b0, ec(3));
    step(1'b1, 1'b1, 4'b0001, 1'b0); outs("sat_v3", 2'd0, 1'b1, 1'b0, 1'b1, ec(3));
    step(1'b1, 1'b1, 4'b0010, 1'b0); outs("sat_l3", 2'd1, 1'b1, 1'b1, 1'b0, ec(3));

    // clr_err together with a violation
    step(1'b1, 1'b1, 4'b1000, 1'b1); outs("clr_viol", 2'd3, 1'b1, 1'b0, 1'b1, ec(0));
    step(1'b1, 1'b1, 4'b0001, 1'b0); outs("clr_relock", 2'd0, 1'b1, 1'b1, 1'b0, ec(0));

    // Build err_count=2 while locked
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("cnt_v1", 2'd2, 1'b1, 1'b0, 1'b1, ec(1));
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("cnt_l1", 2'd3, 1'b1, 1'b1, 1'b0, ec(1));
    step(1'b1, 1'b1, 4'b0010, 1'b0); outs("cnt_v2", 2'd1, 1'b1, 1'b0, 1'b1, ec(2));
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("cnt_l2", 2'd2, 1'b1, 1'b1, 1'b0, ec(2));

    // Reset mid-lock wins over en; then fresh acquisition
    step(1'b0, 1'b1, 4'b1000, 1'b1); outs("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 4'b0100, 1'b0); outs("rst_seed", 2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 4'b1000, 1'b0); outs("rst_lock", 2'd3, 1'b1, 1'b1, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
